// File: rtl/wb_arbiter_pkg.sv
// Shared constants and write-request record for the write-back arbiter.
package wb_arbiter_pkg;

  localparam logic [4:0] REG_LINK      = 5'd31;
  localparam logic [4:0] REG_ZERO      = 5'd0;
  localparam int         WB_FIFO_DEPTH = 2;

  // FIFO occupancy doubles as its state
  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

  typedef struct packed {
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [31:0] pc;
    logic        valid;
  } wreq_t;

endpackage

// File: rtl/wb_fifo2.sv
// Two-entry late-write buffer with squash-by-address and operand lookup.
// Squashed entries are skipped at the head, so they never cost an output slot.
module wb_fifo2 import wb_arbiter_pkg::*; (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_push,
  input  wreq_t      i_push_req,
  input  logic       i_pop_req,
  input  logic       i_sq_en,
  input  logic [4:0] i_sq_addr,
  input  logic [4:0] i_rs,
  input  logic [4:0] i_rt,
  output logic       o_ready,
  output wreq_t      o_head,
  output logic       o_rs_busy,
  output logic       o_rt_busy
);

  wreq_t      r_ent [WB_FIFO_DEPTH];
  logic       r_rptr, r_wptr;
  logic [1:0] r_count;
  logic [1:0] w_pop;
  logic       w_hv, w_nv;

  assign o_ready = (r_count != ST_FULL);

  // Pick the oldest live entry; drop dead heads even while main owns the port
  always_comb begin
    w_hv   = (r_count != ST_EMPTY) && r_ent[r_rptr].valid;
    w_nv   = (r_count == ST_FULL) && r_ent[~r_rptr].valid;
    w_pop  = 2'd0;
    o_head = '0;
    if (r_count != ST_EMPTY) begin
      if (w_hv) begin
        if (i_pop_req) begin
          w_pop  = 2'd1;
          o_head = r_ent[r_rptr];
        end
      end else if (r_count == ST_ONE) begin
        w_pop = 2'd1;
      end else if (w_nv && !i_pop_req) begin
        w_pop = 2'd1;
      end else begin
        w_pop = 2'd2;
        if (w_nv) o_head = r_ent[~r_rptr];
      end
    end
  end

  // Hazard lookup sees only stored, unsquashed entries
  always_comb begin
    o_rs_busy = 1'b0;
    o_rt_busy = 1'b0;
    for (int i = 0; i < WB_FIFO_DEPTH; i++) begin
      if (r_ent[i].valid && (i_rs != REG_ZERO) && (r_ent[i].waddr == i_rs)) o_rs_busy = 1'b1;
      if (r_ent[i].valid && (i_rt != REG_ZERO) && (r_ent[i].waddr == i_rt)) o_rt_busy = 1'b1;
    end
  end

  // Pointer/count update; a fresh push is never squashed (late result is younger)
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_count <= ST_EMPTY;
      r_rptr  <= 1'b0;
      r_wptr  <= 1'b0;
      for (int i = 0; i < WB_FIFO_DEPTH; i++) r_ent[i] <= '0;
    end else begin
      r_count <= r_count - w_pop + {1'b0, i_push};
      r_rptr  <= r_rptr ^ w_pop[0];
      r_wptr  <= r_wptr ^ i_push;
      for (int i = 0; i < WB_FIFO_DEPTH; i++) begin
        if (i_push && (r_wptr == 1'(i)))
          r_ent[i] <= i_push_req;
        else if ((w_pop == 2'd2) || ((w_pop == 2'd1) && (r_rptr == 1'(i))))
          r_ent[i].valid <= 1'b0;
        else if (i_sq_en && (r_ent[i].waddr == i_sq_addr))
          r_ent[i].valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Register-file write-port arbiter: main pipeline always wins, late results
// (load/mul-div) wait in a 2-entry buffer and drain on idle main cycles.
module wb_arbiter import wb_arbiter_pkg::*; (
  input  logic        CLK,
  input  logic        reset,
  input  logic        m_valid,
  input  logic        m_wja,
  input  logic [4:0]  m_waddr,
  input  logic [31:0] m_wdata,
  input  logic [31:0] m_pc,
  input  logic [31:0] m_link,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [4:0]  s_waddr,
  input  logic [31:0] s_wdata,
  input  logic [31:0] s_pc,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  output logic        rs_busy,
  output logic        rt_busy,
  output logic        RegWre,
  output logic        wja,
  output logic [4:0]  WriteReg,
  output logic [31:0] WriteData,
  output logic [31:0] WPC,
  output logic [31:0] jal
);

  logic [4:0]  w_maddr;
  logic        w_mwr, w_push;
  wreq_t       w_sreq, w_head;
  logic        r_wre, r_wja;
  logic [4:0]  r_wreg;
  logic [31:0] r_wdata, r_wpc, r_jal;

  assign w_maddr = m_wja ? REG_LINK : m_waddr;
  assign w_mwr   = m_valid && (w_maddr != REG_ZERO);
  // Writes to $0 are acknowledged but never stored
  assign w_push  = s_valid && s_ready && (s_waddr != REG_ZERO);
  assign w_sreq  = '{waddr: s_waddr, wdata: s_wdata, pc: s_pc, valid: 1'b1};

  wb_fifo2 u_fifo (
    .i_clk      (CLK),
    .i_rst      (reset),
    .i_push     (w_push),
    .i_push_req (w_sreq),
    .i_pop_req  (!m_valid),
    .i_sq_en    (w_mwr),
    .i_sq_addr  (w_maddr),
    .i_rs       (rs),
    .i_rt       (rt),
    .o_ready    (s_ready),
    .o_head     (w_head),
    .o_rs_busy  (rs_busy),
    .o_rt_busy  (rt_busy)
  );

  // Output register: main write, else buffered head, else idle zeros
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      r_wre   <= 1'b0;
      r_wja   <= 1'b0;
      r_wreg  <= '0;
      r_wdata <= '0;
      r_wpc   <= '0;
      r_jal   <= '0;
    end else if (w_mwr) begin
      r_wre   <= 1'b1;
      r_wja   <= m_wja;
      r_wreg  <= w_maddr;
      r_wdata <= m_wja ? 32'd0 : m_wdata;
      r_wpc   <= m_pc;
      r_jal   <= m_wja ? m_link : 32'd0;
    end else if (!m_valid && w_head.valid) begin
      r_wre   <= 1'b1;
      r_wja   <= 1'b0;
      r_wreg  <= w_head.waddr;
      r_wdata <= w_head.wdata;
      r_wpc   <= w_head.pc;
      r_jal   <= '0;
    end else begin
      r_wre   <= 1'b0;
      r_wja   <= 1'b0;
      r_wreg  <= '0;
      r_wdata <= '0;
      r_wpc   <= '0;
      r_jal   <= '0;
    end
  end

  assign RegWre    = r_wre;
  assign wja       = r_wja;
  assign WriteReg  = r_wreg;
  assign WriteData = r_wdata;
  assign WPC       = r_wpc;
  assign jal       = r_jal;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: inputs change on negedge, outputs checked on negedge.
module tb_wb_arbiter;

  logic        CLK = 1'b0, reset;
  logic        m_valid, m_wja, s_valid, s_ready, rs_busy, rt_busy, RegWre, wja;
  logic [4:0]  m_waddr, s_waddr, rs, rt, WriteReg;
  logic [31:0] m_wdata, m_pc, m_link, s_wdata, s_pc, WriteData, WPC, jal;
  int n_pass = 0, n_total = 0;

  wb_arbiter dut (
    .CLK(CLK), .reset(reset), .m_valid(m_valid), .m_wja(m_wja), .m_waddr(m_waddr),
    .m_wdata(m_wdata), .m_pc(m_pc), .m_link(m_link), .s_valid(s_valid), .s_ready(s_ready),
    .s_waddr(s_waddr), .s_wdata(s_wdata), .s_pc(s_pc), .rs(rs), .rt(rt),
    .rs_busy(rs_busy), .rt_busy(rt_busy), .RegWre(RegWre), .wja(wja), .WriteReg(WriteReg),
    .WriteData(WriteData), .WPC(WPC), .jal(jal)
  );

  always #5 CLK = ~CLK;

  task automatic idle_inputs();
    m_valid = 0; m_wja = 0; m_waddr = 0; m_wdata = 0; m_pc = 0; m_link = 0;
    s_valid = 0; s_waddr = 0; s_wdata = 0; s_pc = 0; rs = 0; rt = 0;
  endtask

  task automatic main_wr(input logic [4:0] a, input logic [31:0] d, input logic [31:0] pc);
    m_valid = 1; m_wja = 0; m_waddr = a; m_wdata = d; m_pc = pc;
  endtask

  task automatic late_wr(input logic [4:0] a, input logic [31:0] d, input logic [31:0] pc);
    s_valid = 1; s_waddr = a; s_wdata = d; s_pc = pc;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1;
    #3;
    n_total++; if (RegWre !== 1'b0) $display("FAIL reset_wre: got %0h want 0", RegWre); else n_pass++;
    n_total++; if (WriteData !== 32'd0) $display("FAIL reset_wdata: got %0h want 0", WriteData); else n_pass++;
    n_total++; if (s_ready !== 1'b1) $display("FAIL reset_ready: got %0h want 1", s_ready); else n_pass++;
    @(negedge CLK); reset = 0;
    @(negedge CLK);
  endtask

  task automatic test_main();
    main_wr(5'd5, 32'h1234, 32'h3000);
    @(negedge CLK);
    m_valid = 0;
    n_total++; if (RegWre !== 1'b1) $display("FAIL main_wre: got %0h want 1", RegWre); else n_pass++;
    n_total++; if (WriteReg !== 5'd5) $display("FAIL main_reg: got %0d want 5", WriteReg); else n_pass++;
    n_total++; if (WriteData !== 32'h1234) $display("FAIL main_data: got %0h want 1234", WriteData); else n_pass++;
    n_total++; if (WPC !== 32'h3000) $display("FAIL main_pc: got %0h want 3000", WPC); else n_pass++;
    n_total++; if ({wja, jal} !== 33'd0) $display("FAIL main_jal: got %0h/%0h want 0/0", wja, jal); else n_pass++;
    @(negedge CLK);
    n_total++; if ({RegWre, WriteData} !== 33'd0) $display("FAIL idle_out: got %0h/%0h want 0/0", RegWre, WriteData); else n_pass++;
  endtask

  task automatic test_jal();
    main_wr(5'd3, 32'h55, 32'h3008); m_wja = 1; m_link = 32'h300C;
    @(negedge CLK);
    idle_inputs();
    n_total++; if (wja !== 1'b1) $display("FAIL jal_wja: got %0h want 1", wja); else n_pass++;
    n_total++; if (WriteReg !== 5'd31) $display("FAIL jal_reg: got %0d want 31", WriteReg); else n_pass++;
    n_total++; if (jal !== 32'h300C) $display("FAIL jal_link: got %0h want 300c", jal); else n_pass++;
    n_total++; if (WriteData !== 32'd0) $display("FAIL jal_data: got %0h want 0", WriteData); else n_pass++;
    n_total++; if (WPC !== 32'h3008) $display("FAIL jal_pc: got %0h want 3008", WPC); else n_pass++;
    @(negedge CLK);
  endtask

  task automatic test_backpressure();
    main_wr(5'd20, 32'hA0, 32'h200); late_wr(5'd8, 32'h80, 32'h100);
    @(negedge CLK);
    main_wr(5'd20, 32'hA1, 32'h204); late_wr(5'd9, 32'h90, 32'h104);
    n_total++; if (s_ready !== 1'b1) $display("FAIL bp_ready1: got %0h want 1", s_ready); else n_pass++;
    @(negedge CLK);
    n_total++; if (s_ready !== 1'b0) $display("FAIL bp_full: got %0h want 0", s_ready); else n_pass++;
    n_total++; if (WriteReg !== 5'd20 || WriteData !== 32'hA1) $display("FAIL bp_main: got %0d/%0h want 20/a1", WriteReg, WriteData); else n_pass++;
    rs = 9; rt = 10; #1;
    n_total++; if (rs_busy !== 1'b1) $display("FAIL bp_rs_busy: got %0h want 1", rs_busy); else n_pass++;
    n_total++; if (rt_busy !== 1'b0) $display("FAIL bp_rt_busy: got %0h want 0", rt_busy); else n_pass++;
    m_valid = 0; late_wr(5'd10, 32'hA5, 32'h108);
    @(negedge CLK);
    n_total++; if (RegWre !== 1 || WriteReg !== 5'd8 || WriteData !== 32'h80 || WPC !== 32'h100) $display("FAIL bp_drain8: got %0h/%0d/%0h/%0h want 1/8/80/100", RegWre, WriteReg, WriteData, WPC); else n_pass++;
    n_total++; if (s_ready !== 1'b1) $display("FAIL bp_ready2: got %0h want 1", s_ready); else n_pass++;
    @(negedge CLK);
    s_valid = 0;
    n_total++; if (RegWre !== 1 || WriteReg !== 5'd9 || WriteData !== 32'h90) $display("FAIL bp_drain9: got %0h/%0d/%0h want 1/9/90", RegWre, WriteReg, WriteData); else n_pass++;
    @(negedge CLK);
    n_total++; if (RegWre !== 1 || WriteReg !== 5'd10 || WPC !== 32'h108) $display("FAIL bp_drain10: got %0h/%0d/%0h want 1/10/108", RegWre, WriteReg, WPC); else n_pass++;
    @(negedge CLK);
    n_total++; if (RegWre !== 1'b0 || s_ready !== 1'b1) $display("FAIL bp_empty: got %0h/%0h want 0/1", RegWre, s_ready); else n_pass++;
    idle_inputs();
  endtask

  task automatic test_waw();
    late_wr(5'd7, 32'hAA, 32'h30);
    @(negedge CLK);
    s_valid = 0; main_wr(5'd7, 32'hBB, 32'h40); rt = 7; #1;
    n_total++; if (rt_busy !== 1'b1) $display("FAIL waw_busy_pre: got %0h want 1", rt_busy); else n_pass++;
    @(negedge CLK);
    m_valid = 0;
    n_total++; if (WriteReg !== 5'd7 || WriteData !== 32'hBB) $display("FAIL waw_main: got %0d/%0h want 7/bb", WriteReg, WriteData); else n_pass++;
    n_total++; if (rt_busy !== 1'b0) $display("FAIL waw_busy_post: got %0h want 0", rt_busy); else n_pass++;
    @(negedge CLK);
    n_total++; if (RegWre !== 1'b0) $display("FAIL waw_no_stale: got %0h/%0h want 0", RegWre, WriteData); else n_pass++;
    // squashed head with a live entry behind it: live one comes out with no bubble
    main_wr(5'd20, 32'h1, 32'h0); late_wr(5'd4, 32'h44, 32'h50);
    @(negedge CLK);
    main_wr(5'd4, 32'h99, 32'h60); late_wr(5'd5, 32'h55, 32'h54);
    @(negedge CLK);
    idle_inputs();
    n_total++; if (WriteReg !== 5'd4 || WriteData !== 32'h99) $display("FAIL waw_main4: got %0d/%0h want 4/99", WriteReg, WriteData); else n_pass++;
    @(negedge CLK);
    n_total++; if (RegWre !== 1 || WriteReg !== 5'd5 || WriteData !== 32'h55) $display("FAIL waw_skip: got %0h/%0d/%0h want 1/5/55", RegWre, WriteReg, WriteData); else n_pass++;
    @(negedge CLK);
    n_total++; if (RegWre !== 1'b0) $display("FAIL waw_skip_idle: got %0h want 0", RegWre); else n_pass++;
    // same-cycle late and main to one address: late is younger and is kept
    main_wr(5'd12, 32'h11, 32'h70); late_wr(5'd12, 32'h22, 32'h74);
    @(negedge CLK);
    idle_inputs(); rs = 12; #1;
    n_total++; if (WriteData !== 32'h11 || rs_busy !== 1'b1) $display("FAIL same_main: got %0h/%0h want 11/1", WriteData, rs_busy); else n_pass++;
    @(negedge CLK);
    n_total++; if (RegWre !== 1 || WriteReg !== 5'd12 || WriteData !== 32'h22) $display("FAIL same_late: got %0h/%0d/%0h want 1/12/22", RegWre, WriteReg, WriteData); else n_pass++;
    idle_inputs();
    @(negedge CLK);
  endtask

  task automatic test_zero();
    main_wr(5'd0, 32'hFFFF, 32'h80); late_wr(5'd0, 32'h77, 32'h84);
    @(negedge CLK);
    idle_inputs();
    n_total++; if (RegWre !== 1'b0 || s_ready !== 1'b1) $display("FAIL zero_main: got %0h/%0h want 0/1", RegWre, s_ready); else n_pass++;
    @(negedge CLK);
    n_total++; if (RegWre !== 1'b0) $display("FAIL zero_late: got %0h want 0", RegWre); else n_pass++;
  endtask

  task automatic test_reset_mid();
    main_wr(5'd20, 32'h2, 32'h0); late_wr(5'd8, 32'h8, 32'h90);
    @(negedge CLK);
    late_wr(5'd9, 32'h9, 32'h94);
    @(negedge CLK);
    s_valid = 0; rs = 8;
    #2; reset = 1; #1;
    n_total++; if ({RegWre, WriteReg, WriteData} !== 38'd0) $display("FAIL rst_mid_out: got %0h/%0d/%0h want 0", RegWre, WriteReg, WriteData); else n_pass++;
    n_total++; if (s_ready !== 1'b1 || rs_busy !== 1'b0) $display("FAIL rst_mid_state: got %0h/%0h want 1/0", s_ready, rs_busy); else n_pass++;
    @(negedge CLK);
    reset = 0; idle_inputs();
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      n_total++; if (RegWre !== 1'b0) $display("FAIL rst_mid_ghost%0d: got %0h want 0", i, RegWre); else n_pass++;
    end
    late_wr(5'd11, 32'hB, 32'hA0);
    @(negedge CLK);
    s_valid = 0;
    @(negedge CLK);
    n_total++; if (RegWre !== 1 || WriteReg !== 5'd11 || WriteData !== 32'hB) $display("FAIL rst_first: got %0h/%0d/%0h want 1/11/b", RegWre, WriteReg, WriteData); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_main();
    test_jal();
    test_backpressure();
    test_waw();
    test_zero();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 CLK  input  1  single clock; all state updates on posedge CLK.
REQ-002 reset  input  1  asynchronous, active-high reset.
REQ-003 m_valid  input  1  main-pipeline write request; always accepted, never stalled.
REQ-004 m_wja  input  1  main request is a jal link write to $31.
REQ-005 m_waddr/m_wdata/m_pc/m_link  input  5/32/32/32  main destination, data, instruction PC, link value.
REQ-006 s_valid  input  1  late-result source (load/mul-div) write request.
REQ-007 s_ready  output  1  late source accepted this cycle when s_valid && s_ready.
REQ-008 s_waddr/s_wdata/s_pc  input  5/32/32  late destination, data, PC.
REQ-009 rs/rt  input  5/5  decode-stage operand addresses for hazard query.
REQ-010 rs_busy/rt_busy  output  1/1  a buffered late write targets rs/rt.
REQ-011 RegWre/wja/WriteReg/WriteData/WPC/jal  output  1/1/5/32/32/32  register-file write port, registered.

Function
REQ-012 Late requests SHALL be buffered in a 2-entry FIFO (1-bit read/write pointers plus 2-bit count; count is the state: EMPTY=0, ONE=1, FULL=2).
REQ-013 s_ready SHALL equal (count != 2); no pass-through when FULL, even if a pop occurs the same cycle.
REQ-014 A main request with m_valid=1 SHALL win the output port that cycle; FIFO SHALL not pop.
REQ-015 When m_valid=0 and count!=0, the head entry SHALL pop and drive the output port (wja=0).
REQ-016 Output latency SHALL be exactly 1 cycle: port values presented next posedge; RegWre=0 and other outputs hold 0 on idle cycles.
REQ-017 Main jal: wja=1, WriteReg=31, jal=m_link, WriteData=0; main non-jal: wja=0, WriteReg=m_waddr, WriteData=m_wdata, jal=0.
REQ-018 Any write whose effective destination is 0 (non-jal, address 0) SHALL be dropped: RegWre=0, no output; a late request to $0 SHALL be accepted but not enqueued.
REQ-019 WAW squash: an accepted main write (effective address A != 0) SHALL invalidate every buffered entry with waddr==A the same cycle; squashed entries are popped silently at head without consuming an output cycle.
REQ-020 A late request arriving in the same cycle as a main write to the same address SHALL be enqueued (late result is younger).
REQ-021 Simultaneous push and pop in ONE SHALL leave count at 1; pointers wrap modulo 2.
REQ-022 rs_busy SHALL be 1 iff rs!=0 and a valid, unsquashed stored entry has waddr==rs; rt_busy likewise; combinational from stored state only.
REQ-023 WPC SHALL carry m_pc or the entry s_pc of the write being output.

Reset
REQ-024 Asynchronous assertion of reset SHALL immediately clear count, pointers, entry valid bits and all outputs to 0 (s_ready=1 after reset, busy=0).
REQ-025 Reset mid-operation SHALL discard buffered entries; no write issues for them after release.
REQ-026 First post-reset write SHALL be the first request sampled after reset deassertion.

Structure
REQ-027 Shared package SHALL hold constants REG_LINK=31, REG_ZERO=0, WB_FIFO_DEPTH=2 and the write-request record type (waddr, wdata, pc, valid).
REQ-028 One sub-module wb_fifo2 (2-entry FIFO with per-entry squash-by-address and address-match lookup) is natural; arbitration and output register stay in wb_arbiter.
REQ-029 Implementation target 120-400 lines RTL; no latches; no combinational path from s_valid to s_ready.

Verification
REQ-030 Main only: m_valid=1, m_waddr=5, m_wdata=0x1234, m_pc=0x3000 -> next cycle RegWre=1, WriteReg=5, WriteData=0x1234, WPC=0x3000.
REQ-031 jal: m_wja=1, m_link=0x300C, m_pc=0x3008 -> next cycle wja=1, WriteReg=31, jal=0x300C.
REQ-032 Backpressure: three late writes ($8,$9,$10) while m_valid=1 continuously -> s_ready=0 after two; rs=9 gives rs_busy=1; dropping m_valid drains $8,$9 in order on consecutive cycles, then $10 accepted.
REQ-033 WAW: late $7=0xAA buffered, then main $7=0xBB -> output $7=0xBB only; 0xAA never written; rt=7 busy=0 afterwards.
REQ-034 Zero register: main write $0=0xFFFF and late write $0 -> RegWre stays 0, count stays 0.
REQ-035 Reset with count=2 mid-cycle -> outputs 0 asynchronously, s_ready=1, no buffered write appears after release.
